// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer.
// Samples mid-bit; flags framing errors and waits out line breaks.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Valid,
  output logic       o_RX_Busy,
  output logic       o_RX_Frame_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int HI = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF = CW'(HI);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_START_BIT,
    RX_DATA_BITS,
    RX_STOP_BIT,
    RX_WAIT_HIGH
  } state_t;

  state_t        state;
  logic          sync_1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state          <= IDLE;
      sync_1         <= 1'b1;
      rx_s           <= 1'b1;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      o_RX_Byte      <= '0;
      o_RX_Valid     <= 1'b0;
      o_RX_Busy      <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
    end else begin
      sync_1         <= i_RX_Serial;
      rx_s           <= sync_1;
      o_RX_Valid     <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state     <= RX_START_BIT;
            o_RX_Busy <= 1'b1;
          end
        end
        RX_START_BIT: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= RX_DATA_BITS;
            end else begin
              state     <= IDLE;
              o_RX_Busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA_BITS: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) begin
              idx   <= '0;
              state <= RX_STOP_BIT;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP_BIT: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              o_RX_Byte  <= shreg;
              o_RX_Valid <= 1'b1;
              o_RX_Busy  <= 1'b0;
              state      <= IDLE;
            end else begin
              o_RX_Frame_Err <= 1'b1;
              state          <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A held-low line (break) must not look like a new start bit.
        RX_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            o_RX_Busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          o_RX_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, scoreboard of expected pulses,
// and hand sequences for glitch, break, back-to-back, reset, jitter.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       vld;
  logic       busy;
  logic       ferr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit         err;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_byte;
  } vec_t;

  ev_t        q[$];
  int         vld_cyc[$];
  bit         prev_pulse = 1'b0;
  logic [7:0] last_good  = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst          (rst),
    .i_RX_Serial    (rx),
    .o_RX_Byte      (rx_byte),
    .o_RX_Valid     (vld),
    .o_RX_Busy      (busy),
    .o_RX_Frame_Err (ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (vld || ferr) begin
      chk("pulse_excl", 32'(vld && ferr), 0);
      chk("pulse_consec", 32'(prev_pulse), 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, vld, ferr}, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", 32'(ferr), 32'(e.err));
        chk("pulse_byte", 32'(rx_byte), 32'(e.b));
        chk("busy_at_pulse", 32'(busy), 32'(e.err));
      end
      if (vld) vld_cyc.push_back(cyc);
    end
    prev_pulse = vld || ferr;
  end

  task automatic drive_bit(logic v, int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // jit stretches (+1) or shrinks (-1) every sixth bit by one clock
  task automatic send_frame(logic [7:0] d, logic stop, int jit);
    ev_t e;
    logic [9:0] bits;
    int len;
    if (stop) begin
      e.err = 1'b0; e.b = d; last_good = d;
    end else begin
      e.err = 1'b1; e.b = last_good;
    end
    q.push_back(e);
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      len = CPB + ((i % 6 == 5) ? jit : 0);
      drive_bit(bits[i], len);
    end
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
    q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int base;
    vecs[0] = '{8'hA5, 1'b1, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF};
    vecs[4] = '{8'h81, 1'b0, 8'hFF};
    vecs[5] = '{8'h7E, 1'b1, 8'h7E};

    repeat (3) @(negedge clk);
    chk("rst_byte", 32'(rx_byte), 0);
    chk("rst_valid", 32'(vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(ferr), 0);
    rst = 1'b0;
    drive_bit(1'b1, 4);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop, 0);
      drive_bit(1'b1, 16);
      wait_drain("vec_drain");
      chk("vec_byte", 32'(rx_byte), 32'(vecs[i].exp_byte));
      chk("vec_busy_idle", 32'(busy), 0);
    end

    // short low glitch: busy blips, nothing received
    drive_bit(1'b0, 2);
    rx = 1'b1;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    chk("glitch_busy_hi", 32'(busy), 1);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("glitch_busy_lo", 32'(busy), 0);
    drive_bit(1'b1, 16);
    chk("glitch_byte", 32'(rx_byte), 8'h7E);

    // framing error followed by a long break
    send_frame(8'hA5, 1'b1, 0);
    drive_bit(1'b1, 16);
    send_frame(8'h3C, 1'b0, 0);
    drive_bit(1'b0, 19 * CPB);
    chk("break_busy", 32'(busy), 1);
    chk("break_byte", 32'(rx_byte), 8'hA5);
    wait_drain("break_drain");
    drive_bit(1'b1, 6);
    chk("break_release", 32'(busy), 0);
    drive_bit(1'b1, 16);

    // back-to-back frames, single stop bit between
    base = vld_cyc.size();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    drive_bit(1'b1, 16);
    wait_drain("b2b_drain");
    chk("b2b_count", vld_cyc.size() - base, 2);
    if (vld_cyc.size() - base == 2)
      chk("b2b_gap", vld_cyc[base+1] - vld_cyc[base], 80);
    chk("b2b_byte", 32'(rx_byte), 8'hFF);

    // reset during data bit 4
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
    drive_bit(1'b0, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_byte", 32'(rx_byte), 0);
    chk("mid_rst_valid", 32'(vld), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(ferr), 0);
    rst = 1'b0;
    last_good = 8'h00;
    drive_bit(1'b1, 3 * CPB);
    chk("post_rst_busy", 32'(busy), 0);
    send_frame(8'h5A, 1'b1, 0);
    drive_bit(1'b1, 16);
    wait_drain("post_rst_drain");
    chk("post_rst_byte", 32'(rx_byte), 8'h5A);

    // +/-2% bit period
    send_frame(8'hC3, 1'b1, 1);
    drive_bit(1'b1, 16);
    wait_drain("slow_drain");
    send_frame(8'h00, 1'b1, 0);
    drive_bit(1'b1, 16);
    wait_drain("mid_drain");
    send_frame(8'hC3, 1'b1, -1);
    drive_bit(1'b1, 16);
    wait_drain("fast_drain");
    chk("jitter_byte", 32'(rx_byte), 8'hC3);

    chk("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 868, number of i_Clock cycles per UART bit (25 MHz / 28800 baud); legal values >= 4.
REQ-002 Port: i_Clock  input  1  sole clock; all logic on rising edge.
REQ-003 Port: i_Rst  input  1  reset; synchronous, active-high.
REQ-004 Port: i_RX_Serial  input  1  asynchronous serial line; idle high; format 8N1, LSB first.
REQ-005 Port: o_RX_Byte  output  8  last correctly framed received byte.
REQ-006 Port: o_RX_Valid  output  1  one-cycle pulse; o_RX_Byte updated and valid.
REQ-007 Port: o_RX_Busy  output  1  high while a frame is in progress.
REQ-008 Port: o_RX_Frame_Err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-009 i_RX_Serial SHALL pass through a 2-flop synchronizer; both flops reset to 1. All decisions SHALL use the second flop output (rx_s).
REQ-010 Bit counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide; bit index SHALL be 3 bits; H = (CLKS_PER_BIT-1)/2 (integer division).
REQ-011 States SHALL be IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT, RX_WAIT_HIGH; illegal encodings SHALL go to IDLE next cycle.
REQ-012 IDLE: counter and bit index held 0; rx_s==0 -> RX_START_BIT, o_RX_Busy set 1 on the same edge.
REQ-013 RX_START_BIT: counter increments each cycle; at counter==H, rx_s==0 -> counter 0, RX_DATA_BITS; rx_s==1 -> IDLE, o_RX_Busy 0 (glitch rejected, no pulses).
REQ-014 RX_DATA_BITS: counter increments; at counter==CLKS_PER_BIT-1, shift register bit[index] <= rx_s, counter 0; index<7 -> index+1; index==7 -> index 0, RX_STOP_BIT.
REQ-015 RX_STOP_BIT: at counter==CLKS_PER_BIT-1: rx_s==1 -> o_RX_Byte <= shift register, o_RX_Valid 1 for one cycle, o_RX_Busy 0, IDLE; rx_s==0 -> o_RX_Frame_Err 1 for one cycle, o_RX_Byte unchanged, RX_WAIT_HIGH.
REQ-016 RX_WAIT_HIGH: o_RX_Busy stays 1; rx_s==1 -> o_RX_Busy 0, IDLE; a break (line held low) SHALL NOT start a new frame.
REQ-017 o_RX_Valid and o_RX_Frame_Err SHALL default to 0 every cycle, never high together, never high for consecutive cycles.
REQ-018 Latency: rx_s falling edge seen in IDLE at cycle T -> o_RX_Valid high at T+1+H+9*CLKS_PER_BIT (+/-0 cycles); pin-to-rx_s adds 2 cycles.
REQ-019 Sampling SHALL end mid-stop-bit; a start bit arriving immediately after one stop bit (back-to-back frames) SHALL be received.
REQ-020 o_RX_Byte SHALL hold its value between valid pulses; no input-side handshake (no backpressure); downstream SHALL capture on o_RX_Valid.

Reset
REQ-021 i_Rst high at a rising edge SHALL force: state IDLE, counter 0, index 0, shift register 0, synchronizer 1,1, o_RX_Byte 8'h00, o_RX_Valid 0, o_RX_Busy 0, o_RX_Frame_Err 0.
REQ-022 Reset SHALL take priority over every state, including mid-frame; no pulse SHALL be emitted in the reset cycle or the cycle after.
REQ-023 After reset deassertion, a frame starting no earlier than 2 cycles later SHALL be received correctly.

Verification (CLKS_PER_BIT=8, H=3)
REQ-024 Frame 0xA5, one stop bit -> single o_RX_Valid pulse, o_RX_Byte=8'hA5, o_RX_Frame_Err never 1, busy low after pulse.
REQ-025 Line low for 2 clocks then high -> o_RX_Busy pulses, returns to IDLE, no o_RX_Valid, o_RX_Byte unchanged.
REQ-026 0xA5 received, then frame 0x3C with stop bit 0, line held low 20 bit times -> o_RX_Frame_Err one pulse, o_RX_Byte stays 8'hA5, busy high until line returns high, no further frame.
REQ-027 Back-to-back 0x00 then 0xFF, no idle gap -> two o_RX_Valid pulses 10*8=80 cycles apart, bytes 8'h00 then 8'hFF.
REQ-028 i_Rst asserted during data bit 4 of a frame -> all outputs 0 next edge; subsequent 0x5A frame -> o_RX_Byte=8'h5A, no frame error.
REQ-029 Byte sent at +2% and -2% bit period (8 vs 8.16 clocks emulated by line-side jitter of one clock every 6 bits) -> correct byte 0xC3.
